// File: rtl/result_buffer_pkg.sv
// result_buffer_pkg: frame depth and controller state encodings shared by the result buffer.
package result_buffer_pkg;
    localparam int DEPTH_C = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        FILL  = 2'b00,
        READY = 2'b01,
        DRAIN = 2'b10
    } state_e;
endpackage

// File: rtl/result_buffer_buffer_mem.sv
// buffer_mem: 4-entry register file with one write port and one registered read port.
module buffer_mem
    import result_buffer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH_C];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb rdata_d = re ? mem_q[raddr] : rdata_q;

    // storage is deliberately left out of reset; only the output word is cleared
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/result_buffer.sv
// result_buffer: collects a 4-word frame, then drains it in FIFO order to the consumer.
module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_rdy,
    output logic              frame_done,
    output logic [2:0]        count,
    output logic              ovf
);
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_valid_q, rd_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               ovf_q, ovf_d;
    logic               rd_acc;
    logic               last_rd;

    assign wr_ack  = wr_req && (state_q == FILL);
    assign rd_acc  = rd_req && (state_q == READY || state_q == DRAIN);
    assign last_rd = rd_acc && (count_q == CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        wp_d         = wr_ack ? wp_q + PTR_W'(1) : wp_q;
        rp_d         = rd_acc ? rp_q + PTR_W'(1) : rp_q;
        count_d      = wr_ack ? count_q + CNT_W'(1) : rd_acc ? count_q - CNT_W'(1) : count_q;
        rd_valid_d   = rd_acc;
        frame_done_d = last_rd;
        ovf_d        = ovf_q || (wr_req && state_q != FILL);
        if (wr_ack && count_q == CNT_W'(DEPTH_C - 1)) state_d = READY;
        if (rd_acc && state_q == READY) state_d = DRAIN;
        if (last_rd) begin
            state_d = FILL;
            wp_d    = '0;
            rp_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    buffer_mem #(.DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ack),
        .waddr (wp_q),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rp_q),
        .rdata (rd_data)
    );

    assign rd_valid   = rd_valid_q;
    assign frame_rdy  = (state_q == READY);
    assign frame_done = frame_done_q;
    assign count      = count_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_result_buffer.sv
// tb_result_buffer: table-driven directed checks of the result buffer frame protocol.
module tb_result_buffer;
    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       ack;
        logic [2:0] cnt;
        logic       rv;
        logic [7:0] rdd;
        logic       frdy;
        logic       fd;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_req = 1'b0;
    logic       wr_ack;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_rdy;
    logic       frame_done;
    logic [2:0] count;
    logic       ovf;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    result_buffer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_rdy  (frame_rdy),
        .frame_done (frame_done),
        .count      (count),
        .ovf        (ovf)
    );

    function automatic vec_t v(logic r, logic w, logic [7:0] d, logic q, logic a, logic [2:0] c,
                               logic rv, logic [7:0] rdd, logic fr, logic fd, logic o);
        vec_t t;
        t.rst = r; t.wr = w; t.wd = d; t.rd = q; t.ack = a; t.cnt = c;
        t.rv = rv; t.rdd = rdd; t.frdy = fr; t.fd = fd; t.ovf = o;
        return t;
    endfunction

    task automatic chk(input int idx, input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t t);
        rst = t.rst; wr_req = t.wr; wr_data = t.wd; rd_req = t.rd;
        @(negedge clk);
        chk(idx, "wr_ack", {7'b0, wr_ack}, {7'b0, t.ack});
        @(posedge clk);
        #1;
        chk(idx, "count", {5'b0, count}, {5'b0, t.cnt});
        chk(idx, "rd_valid", {7'b0, rd_valid}, {7'b0, t.rv});
        chk(idx, "rd_data", rd_data, t.rdd);
        chk(idx, "frame_rdy", {7'b0, frame_rdy}, {7'b0, t.frdy});
        chk(idx, "frame_done", {7'b0, frame_done}, {7'b0, t.fd});
        chk(idx, "ovf", {7'b0, ovf}, {7'b0, t.ovf});
    endtask

    // fill 4 words, expecting ack each cycle and frame_rdy after the last
    task automatic fill(input int base, input logic [7:0] w0, input logic rd_too,
                        input logic [7:0] hold, input logic o);
        for (int i = 0; i < 4; i++)
            step(base + i, v(0, 1, w0 + 8'(i), rd_too, 1, 3'(i + 1), 0, hold, i == 3, 0, o));
    endtask

    task automatic drain(input int base, input int n, input logic [7:0] w0, input logic o);
        for (int i = 0; i < n; i++)
            step(base + i, v(0, 0, 8'h00, 1, 0, 3'(3 - i), 1, w0 + 8'(i), 0, i == 3, o));
    endtask

    initial begin
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'h22, 0, 1, 2, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 2, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 2, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'h33, 0, 1, 3, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'h44, 0, 1, 4, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 1, 8'h55, 0, 0, 4, 0, 8'h00, 1, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 3, 1, 8'h11, 0, 0, 1));
        tbl.push_back(v(0, 1, 8'h66, 1, 0, 2, 1, 8'h22, 0, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 1, 1, 8'h33, 0, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 8'h44, 0, 1, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 8'h44, 0, 0, 1));

        @(posedge clk);
        #1;
        foreach (tbl[i]) step(i, tbl[i]);

        // two back-to-back frames with rd_req held during FILL: writes win, pointers wrap
        fill(100, 8'h01, 1, 8'h44, 1);
        drain(110, 4, 8'h01, 1);
        fill(120, 8'hA1, 1, 8'h04, 1);
        drain(130, 4, 8'hA1, 1);
        step(140, v(0, 0, 8'h00, 0, 0, 0, 0, 8'hA4, 0, 0, 1));

        // reset in the middle of a drain discards the frame and clears ovf
        fill(200, 8'hB1, 0, 8'hA4, 1);
        drain(210, 2, 8'hB1, 1);
        step(220, v(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        step(221, v(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
        fill(230, 8'hC1, 0, 8'h00, 0);
        drain(240, 4, 8'hC1, 0);
        step(250, v(0, 0, 8'h00, 0, 0, 0, 0, 8'hC4, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of one result word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning words per frame; the value is fixed at 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_req, input, 1 bit: write strobe from the controller; one word per high cycle.
REQ-006 SHALL have port wr_data, input, DATA_W bits: the word written when wr_req is high.
REQ-007 SHALL have port wr_ack, output, 1 bit: combinational; high when wr_req is accepted this cycle.
REQ-008 SHALL have port rd_req, input, 1 bit: read request from the downstream consumer.
REQ-009 SHALL have port rd_data, output, DATA_W bits: registered read word.
REQ-010 SHALL have port rd_valid, output, 1 bit: registered; rd_data is valid this cycle.
REQ-011 SHALL have port frame_rdy, output, 1 bit: a complete frame of DEPTH words is held and no read has yet been taken.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse coinciding with rd_valid of the last word of a frame.
REQ-013 SHALL have port count, output, 3 bits: number of words currently stored, 0..4.
REQ-014 SHALL have port ovf, output, 1 bit: sticky error flag for a write attempted outside FILL.

Function
REQ-015 SHALL implement the FSM FILL -> READY -> DRAIN -> FILL, with state encoding constants 2'b00, 2'b01, 2'b10.
REQ-016 In FILL, wr_req SHALL be accepted (wr_ack=1), wr_data stored at write pointer, write pointer +1, count +1.
REQ-017 In FILL, when the 4th word is accepted, the FSM SHALL move to READY on that edge; frame_rdy=1 from the next cycle.
REQ-018 In FILL, rd_req SHALL be ignored: no rd_valid, and count unchanged by reads.
REQ-019 In READY, rd_req SHALL move the FSM to DRAIN and perform the first read on the same edge.
REQ-020 In READY or DRAIN, an accepted read SHALL register the entry at the read pointer into rd_data with rd_valid=1 the next cycle (latency 1), then advance the read pointer and decrement count.
REQ-021 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold its last value when rd_valid=0.
REQ-022 Read order SHALL be FIFO: words are read in the order written.
REQ-023 In DRAIN, the read that takes count from 1 to 0 SHALL return the FSM to FILL and assert frame_done alongside that word's rd_valid.
REQ-024 The 2-bit read and write pointers SHALL wrap 3 -> 0; both are 0 at each FILL entry.
REQ-025 A wr_req in READY or DRAIN SHALL be rejected (wr_ack=0, storage unchanged) and SHALL set ovf, which stays set until rst.
REQ-026 For simultaneous wr_req and rd_req, the current state's rule alone SHALL apply; there is never a simultaneous write and read.
REQ-027 rd_req in DRAIN with count=0 cannot occur by construction; rd_req is idle in FILL.

Reset
REQ-028 When rst is high at a clock edge: state=FILL, pointers=0, count=0, rd_valid=0, frame_done=0, ovf=0, rd_data=0.
REQ-029 rst SHALL override all other inputs in that cycle, including mid-frame and mid-drain; partial frames are discarded.
REQ-030 Storage contents need not be cleared by rst.

Structure
REQ-031 State encodings and DEPTH=4 SHALL reside in the shared package / defines file used by the controller.
REQ-032 One sub-module is natural: buffer_mem, a 4 x DATA_W register file with one write port and one registered read port; the FSM and pointers stay in result_buffer.

Verification
REQ-033 Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> wr_ack=1 each cycle; count 1..4; frame_rdy=1 the cycle after 0x44.
REQ-034 From READY, hold rd_req for 4 cycles -> rd_valid with 0x11, 0x22, 0x33, 0x44, each one cycle after its request; frame_done only with 0x44; state FILL; count=0.
REQ-035 wr_req=1 with 0x55 while in READY -> wr_ack=0; ovf=1 next cycle and stays 1; later reads still return 0x11..0x44.
REQ-036 Two full frames back-to-back (0x01..0x04, then 0xA1..0xA4) -> pointer wrap; second drain returns 0xA1..0xA4 in order.
REQ-037 Assert rst after 2 reads in DRAIN -> next cycle count=0, frame_rdy=0, rd_valid=0, ovf=0, state FILL; a fresh 4-word frame then works normally.
REQ-038 rd_req pulses during FILL with count=2 -> no rd_valid, count stays 2.
